soda_ctrl: RTL and testbench

Sequencing controller for the soda-machine dispensing datapath. It accumulates coin credit, decides when the price is met, and pulses `exceed_o` with the registered credit to the dispensing block for one cycle. It captures the dispensing block's `soda`/`change` result and presents it to the vend mechanism over a valid/ready handshake. It also handles cancel and inactivity refunds, and rejects coins while a transaction is in flight.

---
 rtl/soda_pkg.sv | 44 ++++
 rtl/soda_credit_acc.sv | 111 +++++++++++
 rtl/soda_ctrl.sv | 155 +++++++++++++++
 tb/tb_soda_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soda_pkg.sv
`default_nettype none
// ============================================================================
// Module      : soda_pkg
// Description : Shared constants, FSM state type and refund helper for the
//               soda-machine sequencing controller.
// Revision    : 1.0 - initial release
// ============================================================================
package soda_pkg;

    // Coin values and price, in cents
    localparam int PRICE    = 20;
    localparam int NICKEL   = 5;
    localparam int DIME     = 10;
    localparam int QUARTER  = 25;

    // Credit tops out at 15 + 25 = 40; change is counted in nickels
    localparam int CREDIT_W = 6;
    localparam int CHANGE_W = 3;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_COLLECT  = 3'd1,
        S_DISPENSE = 3'd2,
        S_WAIT     = 3'd3,
        S_DELIVER  = 3'd4,
        S_REFUND   = 3'd5
    } state_t;

    // Refund in nickels: credit / 5, clamped to 3 (COLLECT never holds more
    // than 15, so the clamp only guards against an impossible credit).
    function automatic logic [CHANGE_W-1:0] refund_nickels(input logic [CREDIT_W-1:0] credit);
        if (credit >= CREDIT_W'(3 * NICKEL)) begin
            return CHANGE_W'(3);
        end else if (credit >= CREDIT_W'(2 * NICKEL)) begin
            return CHANGE_W'(2);
        end else if (credit >= CREDIT_W'(NICKEL)) begin
            return CHANGE_W'(1);
        end else begin
            return CHANGE_W'(0);
        end
    endfunction

endpackage : soda_pkg
`default_nettype wire

// File: rtl/soda_credit_acc.sv
`default_nettype none
// ============================================================================
// Module      : soda_credit_acc
// Description : Coin decode, illegal-coin detection, credit register and
//               inactivity timeout counter for the soda controller.
// Ports       : clk, rst          - clock, asynchronous active-high reset
//               i_state           - controller FSM state
//               i_nickel/dime/quarter - single-cycle coin pulses
//               i_cancel          - refund request (level)
//               i_clear           - clear credit (handshake completion)
//               o_credit          - registered credit
//               o_coin_ok         - coin sampled this cycle is credited
//               o_coin_rej        - coin(s) sampled this cycle are returned
//               o_price_met       - credited coin brings credit to >= PRICE
//               o_timeout_hit     - inactivity limit reached this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module soda_credit_acc
    import soda_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  state_t              i_state,
    input  logic                i_nickel,
    input  logic                i_dime,
    input  logic                i_quarter,
    input  logic                i_cancel,
    input  logic                i_clear,
    output logic [CREDIT_W-1:0] o_credit,
    output logic                o_coin_ok,
    output logic                o_coin_rej,
    output logic                o_price_met,
    output logic                o_timeout_hit
);

    logic [1:0]          w_coin_cnt;
    logic                w_any_coin;
    logic                w_accepting;
    logic [CREDIT_W-1:0] w_coin_val;
    logic [CREDIT_W-1:0] w_credit_sum;
    logic [CREDIT_W-1:0] r_credit;

    assign w_coin_cnt = {1'b0, i_nickel} + {1'b0, i_dime} + {1'b0, i_quarter};
    assign w_any_coin = i_nickel | i_dime | i_quarter;

    // Coins are only taken while collecting; a simultaneous cancel in COLLECT
    // wins over the coin. Cancel is meaningless in IDLE, so it blocks nothing.
    assign w_accepting = (i_state == S_IDLE) || ((i_state == S_COLLECT) && !i_cancel);

    assign o_coin_ok  = (w_coin_cnt == 2'd1) && w_accepting;
    assign o_coin_rej = w_any_coin && !o_coin_ok;

    always_comb begin
        w_coin_val = '0;
        if (i_nickel) begin
            w_coin_val = CREDIT_W'(NICKEL);
        end else if (i_dime) begin
            w_coin_val = CREDIT_W'(DIME);
        end else if (i_quarter) begin
            w_coin_val = CREDIT_W'(QUARTER);
        end
    end

    assign w_credit_sum = r_credit + w_coin_val;
    assign o_price_met  = o_coin_ok && (w_credit_sum >= CREDIT_W'(PRICE));
    assign o_credit     = r_credit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_credit <= '0;
        end else if (i_clear) begin
            r_credit <= '0;
        end else if (o_coin_ok) begin
            r_credit <= w_credit_sum;
        end
    end

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout
            localparam int c_TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [c_TIMER_W-1:0] c_LIMIT = c_TIMER_W'(TIMEOUT_CYCLES);
            localparam logic [c_TIMER_W-1:0] c_LAST  = c_TIMER_W'(TIMEOUT_CYCLES - 1);
            localparam logic [c_TIMER_W-1:0] c_ONE   = c_TIMER_W'(1);

            logic                 w_counting;
            logic [c_TIMER_W-1:0] r_timer;

            // Only COLLECT cycles without a credited coin count as idle
            assign w_counting = (i_state == S_COLLECT) && !o_coin_ok;

            // The hit fires on the cycle whose edge brings the count to the limit
            assign o_timeout_hit = w_counting && (r_timer == c_LAST);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_timer <= '0;
                end else if (!w_counting) begin
                    r_timer <= '0;
                end else if (r_timer != c_LIMIT) begin
                    r_timer <= r_timer + c_ONE;
                end
            end
        end else begin : g_no_timeout
            assign o_timeout_hit = 1'b0;
        end
    endgenerate

endmodule : soda_credit_acc
`default_nettype wire

// File: rtl/soda_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : soda_ctrl
// Description : Sequencing controller for the soda-machine dispensing path:
//               collects credit, strobes the dispensing block, captures its
//               result and offers it (or a refund) over valid/ready.
// Ports       : clk_i, rst_i           - clock, asynchronous active-high reset
//               nickel_i/dime_i/quarter_i - coin pulses (5/10/25)
//               cancel_i               - refund request
//               deposit_o, exceed_o    - credit and dispense strobe out
//               soda_i, change_i       - dispensing block result
//               vend_valid_o/ready_i   - offer handshake
//               soda_o, change_o       - offered soda / change in nickels
//               reject_o               - coin returned (one cycle later)
//               busy_o                 - transaction in flight
// Revision    : 1.0 - initial release
// ============================================================================
module soda_ctrl
    import soda_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                nickel_i,
    input  logic                dime_i,
    input  logic                quarter_i,
    input  logic                cancel_i,
    output logic [CREDIT_W-1:0] deposit_o,
    output logic                exceed_o,
    input  logic                soda_i,
    input  logic [CHANGE_W-1:0] change_i,
    output logic                vend_valid_o,
    input  logic                vend_ready_i,
    output logic                soda_o,
    output logic [CHANGE_W-1:0] change_o,
    output logic                reject_o,
    output logic                busy_o
);

    state_t              r_state;
    logic                r_exceed;
    logic                r_vend_valid;
    logic                r_soda;
    logic [CHANGE_W-1:0] r_change;
    logic                r_reject;
    logic                r_busy;

    logic [CREDIT_W-1:0] w_credit;
    logic                w_coin_ok;
    logic                w_coin_rej;
    logic                w_price_met;
    logic                w_timeout_hit;
    logic                w_handshake;

    // r_vend_valid is only ever set in DELIVER/REFUND
    assign w_handshake = r_vend_valid && vend_ready_i;

    soda_credit_acc #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_credit_acc (
        .clk           (clk_i),
        .rst           (rst_i),
        .i_state       (r_state),
        .i_nickel      (nickel_i),
        .i_dime        (dime_i),
        .i_quarter     (quarter_i),
        .i_cancel      (cancel_i),
        .i_clear       (w_handshake),
        .o_credit      (w_credit),
        .o_coin_ok     (w_coin_ok),
        .o_coin_rej    (w_coin_rej),
        .o_price_met   (w_price_met),
        .o_timeout_hit (w_timeout_hit)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_exceed     <= 1'b0;
            r_vend_valid <= 1'b0;
            r_soda       <= 1'b0;
            r_change     <= '0;
            r_reject     <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_reject <= w_coin_rej;
            r_exceed <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_coin_ok) begin
                        if (w_price_met) begin
                            r_state  <= S_DISPENSE;
                            r_exceed <= 1'b1;
                            r_busy   <= 1'b1;
                        end else begin
                            r_state <= S_COLLECT;
                        end
                    end
                end

                S_COLLECT: begin
                    if (cancel_i || w_timeout_hit) begin
                        r_state      <= S_REFUND;
                        r_vend_valid <= 1'b1;
                        r_soda       <= 1'b0;
                        r_change     <= refund_nickels(w_credit);
                        r_busy       <= 1'b1;
                    end else if (w_price_met) begin
                        r_state  <= S_DISPENSE;
                        r_exceed <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end

                S_DISPENSE: begin
                    r_state <= S_WAIT;
                end

                // The dispensing block answers one cycle after the strobe
                S_WAIT: begin
                    r_soda       <= soda_i;
                    r_change     <= change_i;
                    r_vend_valid <= 1'b1;
                    r_state      <= S_DELIVER;
                end

                S_DELIVER, S_REFUND: begin
                    if (w_handshake) begin
                        r_vend_valid <= 1'b0;
                        r_soda       <= 1'b0;
                        r_change     <= '0;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign deposit_o    = w_credit;
    assign exceed_o     = r_exceed;
    assign vend_valid_o = r_vend_valid;
    assign soda_o       = r_soda;
    assign change_o     = r_change;
    assign reject_o     = r_reject;
    assign busy_o       = r_busy;

endmodule : soda_ctrl
`default_nettype wire

// File: tb/tb_soda_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_soda_ctrl
// Description : Self-checking bench for soda_ctrl. A transaction-level model
//               of the vending rules predicts per-cycle outputs and vend
//               offers; a monitor pops and compares them independently.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_soda_ctrl;
    import soda_pkg::*;

    localparam int TO = 8;

    logic                clk = 1'b0;
    logic                rst_i = 1'b0;
    logic                nickel_i = 1'b0;
    logic                dime_i = 1'b0;
    logic                quarter_i = 1'b0;
    logic                cancel_i = 1'b0;
    logic [CREDIT_W-1:0] deposit_o;
    logic                exceed_o;
    logic                soda_i = 1'b0;
    logic [CHANGE_W-1:0] change_i = '0;
    logic                vend_valid_o;
    logic                vend_ready_i = 1'b0;
    logic                soda_o;
    logic [CHANGE_W-1:0] change_o;
    logic                reject_o;
    logic                busy_o;

    soda_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .nickel_i     (nickel_i),
        .dime_i       (dime_i),
        .quarter_i    (quarter_i),
        .cancel_i     (cancel_i),
        .deposit_o    (deposit_o),
        .exceed_o     (exceed_o),
        .soda_i       (soda_i),
        .change_i     (change_i),
        .vend_valid_o (vend_valid_o),
        .vend_ready_i (vend_ready_i),
        .soda_o       (soda_o),
        .change_o     (change_o),
        .reject_o     (reject_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int deposit;
        bit exceed;
        bit reject;
        bit valid;
        bit busy;
    } exp_t;

    typedef struct {
        bit soda;
        int change;
    } offer_t;

    exp_t   exp_q[$];
    offer_t offer_q[$];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (vending rules) ----------------
    int m_credit = 0;   // credit held
    int m_idle   = 0;   // consecutive idle collecting cycles
    int m_pipe   = 0;   // 0: none, 1: strobe cycle, 2: result cycle
    bit m_offer  = 0;   // an offer is on the vend interface

    // One clock cycle: drive inputs at negedge, predict post-edge outputs.
    task automatic cyc(input bit n, input bit d, input bit q, input bit c, input bit r);
        exp_t   e;
        offer_t o;
        int     ncoin;
        int     val;
        bit     rej;
        bit     collecting;
        @(negedge clk);
        // Dispensing block stand-in: correct answer only in the result cycle
        if (m_pipe == 2) begin
            soda_i   = 1'b1;
            change_i = 3'((m_credit - PRICE) / NICKEL);
        end else begin
            soda_i   = 1'($urandom);
            change_i = 3'($urandom);
        end
        nickel_i     = n;
        dime_i       = d;
        quarter_i    = q;
        cancel_i     = c;
        vend_ready_i = r;

        ncoin = int'(n) + int'(d) + int'(q);
        val   = n ? NICKEL : (d ? DIME : QUARTER);
        rej   = 1'b0;
        e.exceed = 1'b0;

        if (m_offer) begin
            rej = (ncoin > 0);
            if (r) begin
                m_offer  = 1'b0;
                m_credit = 0;
                m_idle   = 0;
            end
        end else if (m_pipe == 1) begin
            rej    = (ncoin > 0);
            m_pipe = 2;
        end else if (m_pipe == 2) begin
            rej      = (ncoin > 0);
            m_pipe   = 0;
            m_offer  = 1'b1;
            o.soda   = 1'b1;
            o.change = (m_credit - PRICE) / NICKEL;
            offer_q.push_back(o);
        end else begin
            collecting = (m_credit > 0);
            if (collecting && c) begin
                rej      = (ncoin > 0);
                m_offer  = 1'b1;
                m_idle   = 0;
                o.soda   = 1'b0;
                o.change = (m_credit / NICKEL > 3) ? 3 : m_credit / NICKEL;
                offer_q.push_back(o);
            end else if (ncoin == 1) begin
                m_credit += val;
                m_idle = 0;
                if (m_credit >= PRICE) begin
                    m_pipe   = 1;
                    e.exceed = 1'b1;
                end
            end else begin
                rej = (ncoin > 1);
                if (collecting) begin
                    m_idle++;
                    if (m_idle >= TO) begin
                        m_offer  = 1'b1;
                        m_idle   = 0;
                        o.soda   = 1'b0;
                        o.change = (m_credit / NICKEL > 3) ? 3 : m_credit / NICKEL;
                        offer_q.push_back(o);
                    end
                end
            end
        end

        e.deposit = m_credit;
        e.reject  = rej;
        e.valid   = m_offer;
        e.busy    = (m_pipe != 0) || m_offer;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int k, input bit r);
        for (int i = 0; i < k; i++) cyc(0, 0, 0, 0, r);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_deposit"}, 32'(deposit_o), 0);
        chk({tag, "_exceed"}, 32'(exceed_o), 0);
        chk({tag, "_valid"}, 32'(vend_valid_o), 0);
        chk({tag, "_soda"}, 32'(soda_o), 0);
        chk({tag, "_change"}, 32'(change_o), 0);
        chk({tag, "_reject"}, 32'(reject_o), 0);
        chk({tag, "_busy"}, 32'(busy_o), 0);
    endtask

    // Asynchronous reset mid-cycle, released before the following negedge
    task automatic do_reset(input string tag);
        @(negedge clk);
        nickel_i = 0; dime_i = 0; quarter_i = 0; cancel_i = 0; vend_ready_i = 0;
        #2 rst_i = 1'b1;
        #1 check_all_zero(tag);
        @(posedge clk);
        #2 rst_i = 1'b0;
        m_credit = 0; m_idle = 0; m_pipe = 0; m_offer = 1'b0;
        offer_q.delete();
    endtask

    // ---------------- monitor ----------------
    initial begin
        bit     prev_valid;
        offer_t cur;
        exp_t   e;
        prev_valid = 1'b0;
        cur.soda   = 1'b0;
        cur.change = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_i) begin
                prev_valid = 1'b0;
                continue;
            end
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_underflow: got no expectation, required one at %0t", $time);
                continue;
            end
            e = exp_q.pop_front();
            chk("deposit", 32'(deposit_o), 32'(e.deposit));
            chk("exceed", 32'(exceed_o), 32'(e.exceed));
            chk("reject", 32'(reject_o), 32'(e.reject));
            chk("vend_valid", 32'(vend_valid_o), 32'(e.valid));
            chk("busy", 32'(busy_o), 32'(e.busy));
            if (vend_valid_o === 1'b1) begin
                if (!prev_valid) begin
                    if (offer_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL offer_unexpected: got an offer, required none at %0t", $time);
                    end else begin
                        cur = offer_q.pop_front();
                    end
                end
                chk("offer_soda", 32'(soda_o), 32'(cur.soda));
                chk("offer_change", 32'(change_o), 32'(cur.change));
            end
            prev_valid = (vend_valid_o === 1'b1);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int  rc;
        bit  n, d, q, c, r;
        rst_i = 1'b1;
        repeat (2) @(posedge clk);
        #2 check_all_zero("reset");
        rst_i = 1'b0;

        // Four nickels: exact price
        repeat (4) cyc(1, 0, 0, 0, 0);
        idle(3, 0);
        idle(1, 1);
        // Cancel in IDLE does nothing
        cyc(0, 0, 0, 1, 0);
        // Dime then quarter, consumer stalls
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        idle(7, 0);
        idle(1, 1);
        // Maximum credit, coin rejected during DELIVER
        repeat (3) cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        idle(3, 0);
        cyc(1, 0, 0, 0, 0);
        idle(1, 1);
        // Dime then cancel
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 1);
        idle(1, 1);
        // Cancel with a simultaneous nickel
        cyc(0, 1, 0, 0, 0);
        cyc(1, 0, 0, 1, 0);
        idle(1, 1);
        // Illegal coin combinations in IDLE and COLLECT
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0);
        cyc(1, 1, 1, 0, 0);
        cyc(0, 0, 0, 1, 0);
        idle(1, 1);
        // Inactivity timeout
        cyc(1, 0, 0, 0, 0);
        idle(TO, 0);
        idle(1, 1);
        // Reset during WAIT, then start fresh
        repeat (4) cyc(1, 0, 0, 0, 0);
        idle(1, 0);
        do_reset("rst_wait");
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        idle(1, 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rc = int'($urandom_range(0, 99));
            n = 0; d = 0; q = 0;
            if (rc < 60) begin
            end else if (rc < 72) begin
                n = 1;
            end else if (rc < 82) begin
                d = 1;
            end else if (rc < 90) begin
                q = 1;
            end else if (rc < 95) begin
                n = 1'($urandom);
                d = ~n;
                q = 1;
            end else begin
                n = 1; d = 1; q = 1'($urandom);
            end
            c = ($urandom_range(0, 99) < 4);
            r = ($urandom_range(0, 99) < 35);
            cyc(n, d, q, c, r);
        end

        @(posedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_soda_ctrl
`default_nettype wire
